// File: rtl/resp_checker_pkg.sv
// Shared types and constants for the response checker.
package resp_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // MISR polynomial x^25 + x^3 + 1: the MSB feeds back into bits 0 and 3.
  localparam logic [31:0] MISR_TAP_MASK = 32'h0000_0009;

  localparam int unsigned DEFAULT_RESP_W = 25;
  localparam int unsigned DEFAULT_DEPTH  = 10;

endpackage

// File: rtl/resp_misr.sv
// Multiple-input signature register with enable and synchronous clear.
module resp_misr
  import resp_checker_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_RESP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(MISR_TAP_MASK);

  logic [WIDTH-1:0] sig_nxt;

  // Shift left, fold the MSB back through the tap mask, absorb the input word.
  always_comb begin
    sig_nxt = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? TAPS : '0) ^ d;
  end

  // Signature register: reset and clear both zero it; updates only when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/resp_checker.sv
// Compares a stream of DUT responses against a preloaded expected memory,
// counting mismatches, capturing the first one and compacting all responses
// into a MISR signature.
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int unsigned RESP_W = DEFAULT_RESP_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [RESP_W-1:0] exp_data,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    fail_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [RESP_W-1:0] first_fail_diff,
  output logic [RESP_W-1:0] signature
);

  localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [RESP_W-1:0] mem [DEPTH];
  logic              accept;
  logic              run_start;
  logic              mem_we;
  logic [RESP_W-1:0] diff;

  // Handshake, run-start qualification and the combinational compare.
  always_comb begin
    accept    = resp_valid && (state == RUN);
    run_start = start && (state != RUN);
    mem_we    = exp_we && (state == IDLE) && ({1'b0, exp_addr} < DEPTH_EXT);
    diff      = resp_data ^ mem[idx];
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    resp_ready = (state == RUN);
    busy       = (state == RUN);
    done       = (state == DONE);
    pass       = (state == DONE) && (fail_count == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && (idx == LAST_IDX)) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Expected-response memory; deliberately not reset so it survives aborts.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[exp_addr] <= exp_data;
    end
  end

  // Run index and mismatch bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx             <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
    end else if (run_start) begin
      idx             <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
    end else if (accept) begin
      if (idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
      if (diff != '0) begin
        fail_count <= fail_count + 1'b1;
        // A zero count means this is the first mismatch of the run.
        if (fail_count == '0) begin
          first_fail_idx  <= idx;
          first_fail_diff <= diff;
        end
      end
    end
  end

  resp_misr #(
    .WIDTH (RESP_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .en    (accept),
    .d     (resp_data),
    .sig   (signature)
  );

endmodule
